avalon_clint: RTL and testbench
===============================

Name: avalon_clint

Overview:
- Core-local interruptor (CLINT) peripheral. Avalon-MM slave on main-bus crossbar device port 1 (PERIPHERAL range).
- Holds the RISC-V machine timer (mtime/mtimecmp) and the software-interrupt bit (msip).
- Drives the core's timer_interrupt and software_interrupt inputs. Occupies the device slot that currently has no peripheral.

Parameters:
AW, 16, local byte-address width (crossbar passes address[AW-1:0])
DW, 32, data width; only 32 supported
TICK_DIV, 1, mtime increments once every TICK_DIV clk cycles (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
read  input  1  Avalon read request
write  input  1  Avalon write request
address  input  AW  byte address within CLINT
byte_enable  input  DW/8  write byte lanes
writedata  input  DW  write data
readdata  output  DW  read data, valid when read && !waitrequest
waitrequest  output  1  Avalon stall
software_interrupt  output  1  msip[0]
timer_interrupt  output  1  mtime >= mtimecmp, registered

Behaviour:
- Everything is synchronous to clk. Reset is sampled on the rising edge while rst_n=0.
- Register map (word offsets, address[1:0] ignored):
  - 0x0000 msip: bit0 R/W, other bits read 0.
  - 0x4000 mtimecmp[31:0].
  - 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0].
  - 0xBFFC mtime[63:32].
  - Any other address: reads 0, writes ignored, no error.
- Reset values:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0.
  - Prescale counter=0, readdata=0, timer_interrupt=0, software_interrupt=0.
  - waitrequest=0 after reset.
- Writes:
  - Complete in the request cycle; waitrequest=0.
  - Only lanes with byte_enable set are updated. byte_enable=0 is a no-op.
  - Write to msip: bit0 takes writedata[0] when byte_enable[0].
- Reads: fixed one wait state, two-state FSM.
  - IDLE: read=1 -> waitrequest=1 this cycle; readdata registered from the addressed register; go to RESP.
  - RESP: waitrequest=0; readdata holds the value captured at the end of IDLE; return to IDLE.
  - Host holds read/address stable through RESP, per Avalon.
  - write is not accepted in RESP. Waitrequest is low, so it completes there as a normal zero-wait write.
  - Simultaneous read=1 and write=1 is illegal host behaviour. The block treats it as a write only.
- mtime:
  - Prescale counter counts 0..TICK_DIV-1. mtime += 1 (64-bit, wraps FFFF..F -> 0) in the cycle the counter equals TICK_DIV-1.
  - TICK_DIV=1 gives an increment every cycle.
  - A bus write to either mtime half in the same cycle as a tick wins for the written bytes. The tick is dropped for that cycle; the unwritten half keeps its old value, no carry applied.
  - A write to mtime does not reset the prescale counter.
- timer_interrupt:
  - Registered each cycle as (mtime >= mtimecmp), unsigned 64-bit.
  - Compare uses the register values from the previous cycle, giving one cycle of latency after an mtime/mtimecmp change.
  - Level output; it deasserts only when mtimecmp is raised above mtime or mtime wraps.
- software_interrupt: equals msip[0] register output directly (no extra stage).
- Reset mid-read: FSM returns to IDLE, waitrequest=0; an outstanding read is abandoned.
- Reset forces interrupts low immediately at the next edge.

Test Plan:
- Reset, then idle 10 cycles with TICK_DIV=1 -> mtime lo reads 10 (+/- read latency), timer_interrupt=0, waitrequest low except during read wait cycle.
- Write mtimecmp hi=0, lo=20 -> timer_interrupt rises exactly one cycle after mtime reaches 20. Write mtimecmp lo=0xFFFF_FFFF, hi=0xFFFF_FFFF -> it falls one cycle later.
- Write msip=1 with byte_enable=4'b0001 -> software_interrupt=1 next cycle. Write msip=1 with byte_enable=4'b0000 after clearing -> stays 0. Read msip -> 0x1 / 0x0 accordingly.
- Write mtime lo=0xFFFF_FFFE, hi=0 (TICK_DIV=1) -> 2 cycles later mtime hi reads 1, lo wraps to 0. Write mtime hi on a tick cycle -> written value kept, no increment that cycle.
- TICK_DIV=4 -> mtime advances 1 per 4 clocks; 40 clocks -> +10. Partial write byte_enable=4'b0010 data 0x0000AB00 to mtimecmp lo -> only byte1 becomes 0xAB.
- Read unmapped 0x1000 -> readdata=0 with one wait cycle. Assert rst_n=0 during a read's wait cycle -> waitrequest=0 and all registers at reset values next cycle.

Source files
------------

// File: rtl/avalon_clint.sv
// avalon_clint
// Core-local interruptor: RISC-V machine timer (mtime / mtimecmp) and the
// machine software-interrupt bit (msip), behind an Avalon-MM slave port.
//
// Ports:
//   clk                 system clock
//   rst_n               synchronous active-low reset
//   read, write         Avalon requests (read+write together is handled as a write)
//   address             byte address within the CLINT, bits [1:0] ignored
//   byte_enable         write byte lanes
//   writedata           write data
//   readdata            read data, valid when read && !waitrequest
//   waitrequest         stall; high only in the single read wait state
//   software_interrupt  msip[0]
//   timer_interrupt     registered (mtime >= mtimecmp)
//
// Read FSM:
//   state  | meaning
//   IDLE   | no read in flight; a read stalls one cycle and captures readdata
//   RESP   | readdata valid, waitrequest low; always returns to IDLE

module avalon_clint #(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int TICK_DIV = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            read,
    input  logic            write,
    input  logic [AW-1:0]   address,
    input  logic [DW/8-1:0] byte_enable,
    input  logic [DW-1:0]   writedata,
    output logic [DW-1:0]   readdata,
    output logic            waitrequest,
    output logic            software_interrupt,
    output logic            timer_interrupt
);

    localparam logic [AW-1:0] ADDR_MSIP     = AW'(16'h0000);
    localparam logic [AW-1:0] ADDR_MTCMP_LO = AW'(16'h4000);
    localparam logic [AW-1:0] ADDR_MTCMP_HI = AW'(16'h4004);
    localparam logic [AW-1:0] ADDR_MTIME_LO = AW'(16'hBFF8);
    localparam logic [AW-1:0] ADDR_MTIME_HI = AW'(16'hBFFC);

    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(TICK_DIV - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        capture;

    logic [63:0] mtime;
    logic [63:0] mtime_nxt;
    logic [63:0] mtimecmp;
    logic [63:0] mtimecmp_nxt;
    logic        msip;
    logic [CW-1:0] prescale;
    logic        tick;

    logic [AW-3:0] word_addr;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_mt_lo;
    logic        sel_mt_hi;
    logic        wr_active;
    logic [DW-1:0] rd_mux;

    logic        unused_addr_bits;

    assign unused_addr_bits = ^address[1:0];

    // Byte-lane merge of new write data into an existing register half.
    function automatic logic [DW-1:0] merge_bytes(
        input logic [DW-1:0]   old_val,
        input logic [DW-1:0]   new_val,
        input logic [DW/8-1:0] be
    );
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < DW / 8; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Address decode on word address only.
    assign word_addr  = address[AW-1:2];
    assign sel_msip   = (word_addr == ADDR_MSIP[AW-1:2]);
    assign sel_cmp_lo = (word_addr == ADDR_MTCMP_LO[AW-1:2]);
    assign sel_cmp_hi = (word_addr == ADDR_MTCMP_HI[AW-1:2]);
    assign sel_mt_lo  = (word_addr == ADDR_MTIME_LO[AW-1:2]);
    assign sel_mt_hi  = (word_addr == ADDR_MTIME_HI[AW-1:2]);

    // Writes are accepted in any FSM state; an all-zero byte_enable is a no-op
    // and therefore does not suppress the mtime tick either.
    assign wr_active = write && (|byte_enable);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    assign tick = (prescale == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // mtime / mtimecmp / msip
    // ------------------------------------------------------------------
    // A bus write to either mtime half takes priority over the tick; the
    // other half is left untouched (no carry into or out of it).
    always_comb begin
        mtime_nxt = mtime;
        if (wr_active && sel_mt_lo) begin
            mtime_nxt[31:0] = merge_bytes(mtime[31:0], writedata, byte_enable);
        end else if (wr_active && sel_mt_hi) begin
            mtime_nxt[63:32] = merge_bytes(mtime[63:32], writedata, byte_enable);
        end else if (tick) begin
            mtime_nxt = mtime + 64'd1;
        end
    end

    always_comb begin
        mtimecmp_nxt = mtimecmp;
        if (wr_active && sel_cmp_lo) begin
            mtimecmp_nxt[31:0] = merge_bytes(mtimecmp[31:0], writedata, byte_enable);
        end else if (wr_active && sel_cmp_hi) begin
            mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], writedata, byte_enable);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime    <= 64'd0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip     <= 1'b0;
        end else begin
            mtime    <= mtime_nxt;
            mtimecmp <= mtimecmp_nxt;
            if (write && sel_msip && byte_enable[0]) begin
                msip <= writedata[0];
            end
        end
    end

    // Compare uses the current register values, so the interrupt follows an
    // mtime/mtimecmp update by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_interrupt <= 1'b0;
        end else begin
            timer_interrupt <= (mtime >= mtimecmp);
        end
    end

    assign software_interrupt = msip;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        if (sel_msip) begin
            rd_mux = {{(DW-1){1'b0}}, msip};
        end else if (sel_cmp_lo) begin
            rd_mux = mtimecmp[31:0];
        end else if (sel_cmp_hi) begin
            rd_mux = mtimecmp[63:32];
        end else if (sel_mt_lo) begin
            rd_mux = mtime[31:0];
        end else if (sel_mt_hi) begin
            rd_mux = mtime[63:32];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; read together with write is a write, so no read starts.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (read && !write) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        waitrequest = 1'b0;
        capture     = 1'b0;
        if (state == S_IDLE && read && !write) begin
            waitrequest = 1'b1;
            capture     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            readdata <= '0;
        end else if (capture) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_avalon_clint.sv
// Bench for avalon_clint: two instances (TICK_DIV=1 and TICK_DIV=4) share one
// bus; a cycle-level reference model predicts both.
module tb_avalon_clint;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        read;
    logic        write;
    logic [15:0] address;
    logic [3:0]  byte_enable;
    logic [31:0] writedata;
    logic [31:0] readdata0, readdata1;
    logic        wr0, wr1, si0, si1, ti0, ti1;

    avalon_clint #(.AW(16), .DW(32), .TICK_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .address(address),
        .byte_enable(byte_enable), .writedata(writedata), .readdata(readdata0),
        .waitrequest(wr0), .software_interrupt(si0), .timer_interrupt(ti0)
    );

    avalon_clint #(.AW(16), .DW(32), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .address(address),
        .byte_enable(byte_enable), .writedata(writedata), .readdata(readdata1),
        .waitrequest(wr1), .software_interrupt(si1), .timer_interrupt(ti1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned divs [2] = '{1, 4};
    logic [63:0] m_mt  [2];
    logic [63:0] m_cmp [2];
    logic        m_msip[2];
    logic        m_ti  [2];
    logic        m_pend[2];
    logic [31:0] m_rd  [2];
    int unsigned m_cyc;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int i, input logic [15:0] a);
        case (a & 16'hFFFC)
            16'h0000: return {31'd0, m_msip[i]};
            16'h4000: return m_cmp[i][31:0];
            16'h4004: return m_cmp[i][63:32];
            16'hBFF8: return m_mt[i][31:0];
            16'hBFFC: return m_mt[i][63:32];
            default:  return 32'd0;
        endcase
    endfunction

    // Applies what the coming clock edge does, given the inputs now driven.
    task automatic model_step();
        logic [15:0] a;
        logic        tk, wr_on, old_ge;
        a = address & 16'hFFFC;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_mt[i] = 64'd0; m_cmp[i] = '1; m_msip[i] = 1'b0;
                m_ti[i] = 1'b0;  m_pend[i] = 1'b0; m_rd[i] = 32'd0;
            end else begin
                old_ge = (m_mt[i] >= m_cmp[i]);
                tk     = ((m_cyc % divs[i]) == divs[i] - 1);
                wr_on  = write && (byte_enable != 4'd0);
                if (!m_pend[i] && read && !write) begin
                    m_rd[i]   = m_read(i, address);
                    m_pend[i] = 1'b1;
                end else begin
                    m_pend[i] = 1'b0;
                end
                if (write && a == 16'h0000 && byte_enable[0]) m_msip[i] = writedata[0];
                if (wr_on && a == 16'h4000) m_cmp[i][31:0]  = merge(m_cmp[i][31:0], writedata, byte_enable);
                if (wr_on && a == 16'h4004) m_cmp[i][63:32] = merge(m_cmp[i][63:32], writedata, byte_enable);
                if (wr_on && a == 16'hBFF8)      m_mt[i][31:0]  = merge(m_mt[i][31:0], writedata, byte_enable);
                else if (wr_on && a == 16'hBFFC) m_mt[i][63:32] = merge(m_mt[i][63:32], writedata, byte_enable);
                else if (tk)                     m_mt[i] = m_mt[i] + 64'd1;
                m_ti[i] = old_ge;
            end
        end
        if (!rst_n) m_cyc = 0;
        else        m_cyc++;
    endtask

    task automatic check_model();
        chk("ti_div1", ti0, m_ti[0]);
        chk("ti_div4", ti1, m_ti[1]);
        chk("si_div1", si0, m_msip[0]);
        chk("si_div4", si1, m_msip[1]);
        chk("waitreq_div1", wr0, read && !write && !m_pend[0]);
        chk("waitreq_div4", wr1, read && !write && !m_pend[1]);
        chk("readdata_div1", readdata0, m_rd[0]);
        chk("readdata_div4", readdata1, m_rd[1]);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; read = 1'b0; write = 1'b0; byte_enable = 4'd0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
        address = a; byte_enable = be; writedata = d; write = 1'b1; read = 1'b0;
        #1;
        chk("write_no_wait", wr0, 1'b0);
        step();
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d0, output logic [31:0] d1);
        address = a; read = 1'b1; write = 1'b0;
        #1;
        chk("read_wait_div1", wr0, 1'b1);
        chk("read_wait_div4", wr1, 1'b1);
        step();
        chk("read_resp_nowait", wr0, 1'b0);
        d0 = readdata0;
        d1 = readdata1;
        step();
        read = 1'b0;
    endtask

    typedef struct {
        bit          is_rd;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_si;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0, d1, a0, a1, b0, b1;
        logic [15:0] ra;
        logic [31:0] rdat;
        int nst;
        bit found;

        rst_n = 1'b0; read = 1'b0; write = 1'b0;
        address = 16'd0; byte_enable = 4'd0; writedata = 32'd0;
        m_cyc = 0;

        // Reset, idle 10 cycles, read mtime lo.
        do_reset();
        chk("rst_ti", ti0, 1'b0);
        chk("rst_waitreq", wr0, 1'b0);
        chk("rst_readdata", readdata0, 32'd0);
        repeat (10) step();
        bus_read(16'hBFF8, d0, d1);
        chk("idle10_mtime_div1", d0, 32'd10);
        chk("idle10_mtime_div4", d1, 32'd2);
        chk("idle10_ti", ti0, 1'b0);

        // Register-map vectors.
        vecs.push_back('{0, 16'h4000, 4'hF, 32'h1234_5678, 32'd0, 1'b0});
        vecs.push_back('{1, 16'h4000, 4'h0, 32'd0, 32'h1234_5678, 1'b0});
        vecs.push_back('{0, 16'h4002, 4'b0010, 32'h0000_AB00, 32'd0, 1'b0});
        vecs.push_back('{1, 16'h4000, 4'h0, 32'd0, 32'h1234_AB78, 1'b0});
        vecs.push_back('{1, 16'h4004, 4'h0, 32'd0, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{0, 16'h0000, 4'b0001, 32'h0000_0001, 32'd0, 1'b1});
        vecs.push_back('{1, 16'h0000, 4'h0, 32'd0, 32'h0000_0001, 1'b1});
        vecs.push_back('{0, 16'h0000, 4'hF, 32'hFFFF_FFFE, 32'd0, 1'b0});
        vecs.push_back('{1, 16'h0000, 4'h0, 32'd0, 32'h0000_0000, 1'b0});
        vecs.push_back('{0, 16'h0000, 4'h0, 32'h0000_0001, 32'd0, 1'b0});
        vecs.push_back('{1, 16'h0000, 4'h0, 32'd0, 32'h0000_0000, 1'b0});
        vecs.push_back('{0, 16'h0001, 4'hF, 32'hFFFF_FFFF, 32'd0, 1'b1});
        vecs.push_back('{1, 16'h0000, 4'h0, 32'd0, 32'h0000_0001, 1'b1});
        vecs.push_back('{1, 16'h1000, 4'h0, 32'd0, 32'h0000_0000, 1'b1});
        vecs.push_back('{0, 16'h1000, 4'hF, 32'hDEAD_BEEF, 32'd0, 1'b1});
        vecs.push_back('{1, 16'h1000, 4'h0, 32'd0, 32'h0000_0000, 1'b1});
        vecs.push_back('{0, 16'h4004, 4'b1000, 32'h1200_0000, 32'd0, 1'b1});
        vecs.push_back('{1, 16'h4004, 4'h0, 32'd0, 32'h12FF_FFFF, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_rd) begin
                bus_read(vecs[i].addr, d0, d1);
                chk($sformatf("vec%0d_rd_div1", i), d0, vecs[i].exp_rd);
                chk($sformatf("vec%0d_rd_div4", i), d1, vecs[i].exp_rd);
            end else begin
                bus_write(vecs[i].addr, vecs[i].be, vecs[i].data);
                chk($sformatf("vec%0d_si_div1", i), si0, vecs[i].exp_si);
                chk($sformatf("vec%0d_si_div4", i), si1, vecs[i].exp_si);
            end
        end

        // Timer interrupt rises one cycle after mtime reaches 20.
        do_reset();
        bus_write(16'h4004, 4'hF, 32'd0);
        bus_write(16'h4000, 4'hF, 32'd20);
        nst = 2;
        found = 0;
        while (nst < 60 && !found) begin
            step();
            nst++;
            if (ti0 === 1'b1) found = 1;
        end
        chk("ti_rise_cycle", nst, 21);
        bus_write(16'h4000, 4'hF, 32'hFFFF_FFFF);
        chk("ti_after_cmp_lo", ti0, 1'b1);
        bus_write(16'h4004, 4'hF, 32'hFFFF_FFFF);
        chk("ti_fall", ti0, 1'b0);

        // mtime carry from lo into hi.
        bus_write(16'hBFF8, 4'hF, 32'hFFFF_FFFE);
        bus_write(16'hBFFC, 4'hF, 32'd0);
        step();
        step();
        bus_read(16'hBFFC, d0, d1);
        chk("wrap_hi", d0, 32'd1);
        bus_read(16'hBFF8, d0, d1);
        chk("wrap_lo", d0, 32'd2);

        // Write to mtime hi on a tick cycle drops the tick.
        bus_write(16'hBFF8, 4'hF, 32'd100);
        bus_write(16'hBFFC, 4'hF, 32'h55);
        bus_read(16'hBFF8, d0, d1);
        chk("hiwr_lo_held", d0, 32'd100);
        bus_read(16'hBFFC, d0, d1);
        chk("hiwr_hi", d0, 32'h55);

        // 40 clocks: +40 at TICK_DIV=1, +10 at TICK_DIV=4.
        bus_read(16'hBFF8, a0, a1);
        repeat (38) step();
        bus_read(16'hBFF8, b0, b1);
        chk("delta40_div1", b0 - a0, 32'd40);
        chk("delta40_div4", b1 - a1, 32'd10);

        // Randomized traffic against the model.
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 6))
                0: ra = 16'h0000;
                1: ra = 16'h4000;
                2: ra = 16'h4004;
                3: ra = 16'hBFF8;
                4: ra = 16'hBFFC;
                5: ra = 16'h1000;
                default: ra = 16'($urandom);
            endcase
            ra = ra | 16'($urandom_range(0, 3));
            if ((ra & 16'hFFFC) == 16'h4004 || (ra & 16'hFFFC) == 16'hBFFC)
                rdat = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 2));
            else if ((ra & 16'hFFFC) == 16'h4000)
                rdat = 32'($urandom_range(0, 4000));
            else
                rdat = $urandom;
            case ($urandom_range(0, 9))
                0, 1:    step();
                2, 3, 4: bus_write(ra, 4'($urandom), rdat);
                5:       begin
                    address = ra; byte_enable = 4'($urandom); writedata = rdat;
                    read = 1'b1; write = 1'b1;
                    #1;
                    chk("rw_no_wait", wr0, 1'b0);
                    step();
                    read = 1'b0; write = 1'b0;
                end
                default: bus_read(ra, d0, d1);
            endcase
        end

        // Reset during a read's wait cycle.
        bus_write(16'h0000, 4'b0001, 32'd1);
        bus_write(16'h4004, 4'hF, 32'd0);
        bus_write(16'h4000, 4'hF, 32'd0);
        step();
        step();
        chk("pre_rst_si", si0, 1'b1);
        chk("pre_rst_ti", ti0, 1'b1);
        address = 16'hBFF8; read = 1'b1; write = 1'b0; rst_n = 1'b0;
        #1;
        chk("midrd_wait", wr0, 1'b1);
        step();
        rst_n = 1'b1; read = 1'b0;
        #1;
        chk("midrd_waitreq", wr0, 1'b0);
        chk("midrd_ti", ti0, 1'b0);
        chk("midrd_si", si0, 1'b0);
        chk("midrd_readdata", readdata0, 32'd0);
        bus_read(16'h4004, d0, d1);
        chk("midrd_cmp_hi", d0, 32'hFFFF_FFFF);
        bus_read(16'h0000, d0, d1);
        chk("midrd_msip", d0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
